// File: rtl/spi_slave_sync_pkg.sv
// Shared types and mode-decode helpers for the oversampling SPI slave.
package spi_slave_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
  function automatic logic sample_sel(input logic cpha, input logic lead, input logic trail);
    return cpha ? trail : lead;
  endfunction

  function automatic logic shift_sel(input logic cpha, input logic lead, input logic trail);
    return cpha ? lead : trail;
  endfunction

endpackage

// File: rtl/spi_slave_sync_sync.sv
// N-stage synchroniser with a configurable reset level.
module spi_slave_sync_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= {STAGES{RST_VAL}};
    else        pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave clocked entirely by i_Clk; SCLK/CS/MOSI are oversampled and edge-detected.
module spi_slave_sync
  import spi_slave_sync_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 8,
  parameter int                    CPOL        = 0,
  parameter int                    CPHA        = 0,
  parameter int                    MSB_FIRST   = 1,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [WORD_WIDTH-1:0] TX_IDLE     = '1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_CS_n,
  input  logic                  i_SPI_Mosi,
  output logic                  o_SPI_Miso,
  output logic                  o_SPI_Miso_En,
  output logic [WORD_WIDTH-1:0] o_Rx_Data,
  output logic                  o_Rx_Valid,
  input  logic [WORD_WIDTH-1:0] i_Tx_Data,
  input  logic                  i_Tx_Valid,
  output logic                  o_Tx_Ready,
  output logic                  o_Tx_Underrun,
  output logic                  o_Busy
);

  localparam int              CW         = $clog2(WORD_WIDTH);
  localparam logic            IDLE_CLK   = (CPOL != 0);
  localparam logic            SHIFT_LEAD = (CPHA != 0);
  localparam logic            MSB        = (MSB_FIRST != 0);
  localparam logic [CW-1:0]   LAST_BIT   = CW'(WORD_WIDTH - 1);
  localparam logic [2:0]      SYNC_RST   = {1'b0, 1'b1, IDLE_CLK};  // {mosi, cs, sclk}

  logic [2:0] pin_raw, pin_syn;
  logic       sclk_s, cs_s, mosi_s, sclk_d, cs_d;
  logic       lead, trail, smp, shf, cs_fall;

  assign pin_raw = {i_SPI_Mosi, i_SPI_CS_n, i_SPI_Clk};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    spi_slave_sync_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[g])) u_sync (
      .clk   (i_Clk),
      .rst_n (i_Rst_L),
      .d     (pin_raw[g]),
      .q     (pin_syn[g])
    );
  end

  assign {mosi_s, cs_s, sclk_s} = pin_syn;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sclk_d <= IDLE_CLK;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign lead    = (sclk_s != IDLE_CLK) && (sclk_d == IDLE_CLK);
  assign trail   = (sclk_s == IDLE_CLK) && (sclk_d != IDLE_CLK);
  assign smp     = sample_sel(SHIFT_LEAD, lead, trail);
  assign shf     = shift_sel(SHIFT_LEAD, lead, trail);
  assign cs_fall = cs_d && !cs_s;

  spi_state_e state, nxt;
  logic       do_load, active;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (cs_fall) nxt = ST_LOAD;
      ST_LOAD:  nxt = cs_s ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (cs_s) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    do_load = (state == ST_LOAD);
    active  = (state == ST_SHIFT) && !cs_s;
  end

  logic [CW-1:0]         bit_cnt;
  logic [WORD_WIDTH-1:0] rx_shift, rx_next, rx_data;
  logic [WORD_WIDTH-1:0] tx_shift, tx_step, hold_data;
  logic [1:0]            vld_pipe;
  logic                  word_end, word_start, tx_acc;
  logic                  hold_full, reload_pend, skip_lead, idle_word, underrun;

  assign rx_next    = MSB ? {rx_shift[WORD_WIDTH-2:0], mosi_s} : {mosi_s, rx_shift[WORD_WIDTH-1:1]};
  assign tx_step    = MSB ? {tx_shift[WORD_WIDTH-2:0], 1'b0} : {1'b0, tx_shift[WORD_WIDTH-1:1]};
  assign word_end   = active && smp && (bit_cnt == LAST_BIT);
  assign word_start = do_load || (active && shf && reload_pend);
  assign tx_acc     = i_Tx_Valid && !hold_full;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], word_end};
      if (!active)  bit_cnt <= '0;
      else if (smp) bit_cnt <= word_end ? '0 : bit_cnt + CW'(1);
      if (active && smp) rx_shift <= rx_next;
      if (word_end)      rx_data  <= rx_next;
    end
  end

  // Underrun is flagged on the first sample of an idle-filled word, so the
  // speculative reload after the last word of a burst never reports one.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      reload_pend <= 1'b0;
      skip_lead   <= 1'b0;
      idle_word   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      underrun <= active && smp && (bit_cnt == '0) && idle_word;
      if (tx_acc) begin
        hold_data <= i_Tx_Data;
        hold_full <= 1'b1;
      end else if (word_start && hold_full) begin
        hold_full <= 1'b0;
      end
      if (state == ST_IDLE) begin
        tx_shift    <= '0;
        reload_pend <= 1'b0;
        skip_lead   <= 1'b0;
        idle_word   <= 1'b0;
      end else if (word_start) begin
        tx_shift    <= hold_full ? hold_data : TX_IDLE;
        idle_word   <= !hold_full;
        reload_pend <= 1'b0;
        skip_lead   <= do_load && SHIFT_LEAD;
      end else begin
        if (word_end) reload_pend <= 1'b1;
        if (active && shf) begin
          if (skip_lead) skip_lead <= 1'b0;
          else           tx_shift  <= tx_step;
        end
      end
    end
  end

  assign o_SPI_Miso_En = !cs_s;
  assign o_Busy        = !cs_s;
  assign o_SPI_Miso    = !cs_s && (MSB ? tx_shift[WORD_WIDTH-1] : tx_shift[0]);
  assign o_Rx_Data     = rx_data;
  assign o_Rx_Valid    = vld_pipe[1];
  assign o_Tx_Ready    = !hold_full;
  assign o_Tx_Underrun = underrun;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench: four 8-bit slaves (modes 0..3) share one bus, plus a 16-bit LSB-first slave.
module tb_spi_slave_sync;

  localparam int H = 5;  // i_Clk cycles per SCLK half period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sclk, cs8_n, cs16_n, mosi0, mosi1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [3:0] miso, miso_en, rx_valid, tx_ready, underrun, busy;
  logic [3:0][7:0] rx_data;
  logic [15:0] tx16_data, rx16_data;
  logic tx16_valid, miso16, miso16_en, rx16_valid, tx16_ready, und16, busy16;

  int ncmp = 0, nfail = 0;
  int rx_cnt [5] = '{default: 0};
  int und_cnt[5] = '{default: 0};
  logic [7:0]  cap [4];
  logic [15:0] cap16;
  int base_rx, base_und, base_rx1, base_und3;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic sclk_g, mosi_g;
    assign sclk_g = (g >= 2) ? ~sclk : sclk;
    assign mosi_g = (g % 2 == 1) ? mosi1 : mosi0;
    spi_slave_sync #(.WORD_WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1),
                     .SYNC_STAGES(2), .TX_IDLE(8'hFF)) u_dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_SPI_Clk(sclk_g), .i_SPI_CS_n(cs8_n),
      .i_SPI_Mosi(mosi_g), .o_SPI_Miso(miso[g]), .o_SPI_Miso_En(miso_en[g]),
      .o_Rx_Data(rx_data[g]), .o_Rx_Valid(rx_valid[g]), .i_Tx_Data(tx_data),
      .i_Tx_Valid(tx_valid), .o_Tx_Ready(tx_ready[g]), .o_Tx_Underrun(underrun[g]),
      .o_Busy(busy[g])
    );
  end

  spi_slave_sync #(.WORD_WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0),
                   .SYNC_STAGES(2), .TX_IDLE(16'hFFFF)) u_dut16 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_SPI_Clk(sclk), .i_SPI_CS_n(cs16_n),
    .i_SPI_Mosi(mosi0), .o_SPI_Miso(miso16), .o_SPI_Miso_En(miso16_en),
    .o_Rx_Data(rx16_data), .o_Rx_Valid(rx16_valid), .i_Tx_Data(tx16_data),
    .i_Tx_Valid(tx16_valid), .o_Tx_Ready(tx16_ready), .o_Tx_Underrun(und16),
    .o_Busy(busy16)
  );

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rx_valid[k]) rx_cnt[k]  <= rx_cnt[k] + 1;
      if (underrun[k]) und_cnt[k] <= und_cnt[k] + 1;
    end
    if (rx16_valid) rx_cnt[4]  <= rx_cnt[4] + 1;
    if (und16)      und_cnt[4] <= und_cnt[4] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push8(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_drop", {31'd0, tx_ready[0]}, 32'd0);
  endtask

  task automatic cs_start(input bit s16);
    if (s16) cs16_n = 1'b0; else cs8_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end(input bit s16);
    repeat (H) @(negedge clk);
    if (s16) cs16_n = 1'b1; else cs8_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Master: data set half a period before the sampling edge of each phase.
  task automatic send_bits(input logic [31:0] word, input int w, input bit msb, input int nbits);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = msb ? word[w-1-i] : word[i];
      mosi0 = b;
      repeat (H) @(negedge clk);
      cap[0] = {cap[0][6:0], miso[0]};
      cap[2] = {cap[2][6:0], miso[2]};
      cap16  = {miso16, cap16[15:1]};
      sclk = 1'b1; mosi1 = b;
      repeat (H) @(negedge clk);
      cap[1] = {cap[1][6:0], miso[1]};
      cap[3] = {cap[3][6:0], miso[3]};
      sclk = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs8_n = 1'b1; cs16_n = 1'b1; mosi0 = 1'b0; mosi1 = 1'b0;
    tx_data = '0; tx_valid = 1'b0; tx16_data = '0; tx16_valid = 1'b0;
    for (int k = 0; k < 4; k++) cap[k] = '0;
    cap16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready",    {31'd0, tx_ready[0]}, 32'd1);
    chk("rst_busy",     {31'd0, busy[0]},     32'd0);
    chk("rst_miso_en",  {31'd0, miso_en[0]},  32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid[0]}, 32'd0);
    chk("rst_rx_data",  {24'd0, rx_data[0]},  32'd0);
    chk("rst_underrun", {31'd0, underrun[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Mode 0 basic exchange
    push8(8'hA5);
    base_rx = rx_cnt[0]; base_und = und_cnt[0];
    cs_start(0);
    chk("busy_on", {31'd0, busy[0]}, 32'd1);
    send_bits(32'h3C, 8, 1, 8);
    cs_end(0);
    chk("m0_rx",   {24'd0, rx_data[0]}, 32'h3C);
    chk("m0_miso", {24'd0, cap[0]},     32'hA5);
    chk("m0_rxv",  rx_cnt[0] - base_rx, 32'd1);
    chk("m0_und",  und_cnt[0] - base_und, 32'd0);
    chk("busy_off", {31'd0, busy[0]}, 32'd0);

    // All modes, 0x96 in / 0x5A out
    push8(8'h5A);
    base_rx = rx_cnt[1]; base_rx1 = rx_cnt[3];
    cs_start(0);
    send_bits(32'h96, 8, 1, 8);
    cs_end(0);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("mode%0d_rx", k),   {24'd0, rx_data[k]}, 32'h96);
      chk($sformatf("mode%0d_miso", k), {24'd0, cap[k]},     32'h5A);
    end
    chk("mode1_rxv", rx_cnt[1] - base_rx,  32'd1);
    chk("mode3_rxv", rx_cnt[3] - base_rx1, 32'd1);

    // Back-to-back words, only the first one queued
    push8(8'h11);
    base_rx = rx_cnt[0]; base_und = und_cnt[0]; base_und3 = und_cnt[3];
    cs_start(0);
    send_bits(32'h01, 8, 1, 8);
    chk("b2b_rx0",   {24'd0, rx_data[0]}, 32'h01);
    chk("b2b_miso0", {24'd0, cap[0]},     32'h11);
    chk("b2b_m3_0",  {24'd0, cap[3]},     32'h11);
    send_bits(32'h02, 8, 1, 8);
    chk("b2b_rx1",   {24'd0, rx_data[0]}, 32'h02);
    chk("b2b_miso1", {24'd0, cap[0]},     32'hFF);
    send_bits(32'h03, 8, 1, 8);
    chk("b2b_rx2",   {24'd0, rx_data[0]}, 32'h03);
    chk("b2b_miso2", {24'd0, cap[0]},     32'hFF);
    chk("b2b_m3_2",  {24'd0, cap[3]},     32'hFF);
    cs_end(0);
    chk("b2b_rxv",  rx_cnt[0] - base_rx,    32'd3);
    chk("b2b_und",  und_cnt[0] - base_und,  32'd2);
    chk("b2b_und3", und_cnt[3] - base_und3, 32'd2);

    // CS raised after 5 bits, then a full word
    base_rx = rx_cnt[0]; base_rx1 = rx_cnt[1];
    cs_start(0);
    send_bits(32'hAA, 8, 1, 5);
    cs_end(0);
    chk("part_rxv",  rx_cnt[0] - base_rx, 32'd0);
    chk("part_hold", {24'd0, rx_data[0]}, 32'h03);
    cs_start(0);
    send_bits(32'hC3, 8, 1, 8);
    cs_end(0);
    chk("after_part_rx",   {24'd0, rx_data[0]}, 32'hC3);
    chk("after_part_rxv",  rx_cnt[0] - base_rx,  32'd1);
    chk("after_part_rx1",  {24'd0, rx_data[1]}, 32'hC3);
    chk("after_part_rxv1", rx_cnt[1] - base_rx1, 32'd1);

    // 16-bit LSB-first slave
    tx16_data = 16'hBEEF; tx16_valid = 1'b1;
    @(negedge clk);
    tx16_valid = 1'b0;
    chk("w16_ready", {31'd0, tx16_ready}, 32'd0);
    base_rx = rx_cnt[4];
    cs_start(1);
    send_bits(32'h1234, 16, 0, 16);
    cs_end(1);
    chk("w16_rx",   {16'd0, rx16_data}, 32'h1234);
    chk("w16_miso", {16'd0, cap16},     32'hBEEF);
    chk("w16_rxv",  rx_cnt[4] - base_rx, 32'd1);

    // Async reset mid-word
    cs_start(0);
    send_bits(32'hF0, 8, 1, 3);
    push8(8'h77);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",   {31'd0, tx_ready[0]}, 32'd1);
    chk("mid_rst_busy",    {31'd0, busy[0]},     32'd0);
    chk("mid_rst_miso_en", {31'd0, miso_en[0]},  32'd0);
    chk("mid_rst_miso",    {31'd0, miso[0]},     32'd0);
    chk("mid_rst_rx",      {24'd0, rx_data[0]},  32'd0);
    @(negedge clk);
    cs8_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy[0]}, 32'd0);
    push8(8'h3C);
    base_rx = rx_cnt[0];
    cs_start(0);
    send_bits(32'h81, 8, 1, 8);
    cs_end(0);
    chk("post_rst_rx",   {24'd0, rx_data[0]}, 32'h81);
    chk("post_rst_miso", {24'd0, cap[0]},     32'h3C);
    chk("post_rst_rxv",  rx_cnt[0] - base_rx, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
